// File: rtl/frame_buffer_pkg.sv
// Shared types and constants for the double-buffered frame store.
// State codes are plain constants so older tools and waveform scripts can match them by value.
package frame_buffer_pkg;

    localparam int PKG_AW = 7;
    localparam int PKG_DW = 12;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t DRAIN   = 2'd1;
    localparam state_t WAIT_VS = 2'd2;
    localparam state_t CLEAR   = 2'd3;

    typedef logic [PKG_DW-1:0]   pixel_t;
    typedef logic [2*PKG_AW-1:0] pix_addr_t;

    localparam pixel_t DEFAULT_BG = 12'h000;

endpackage

// File: rtl/frame_buffer_sync_fifo.sv
// Small synchronous show-ahead FIFO between the pixel writer and the back bank.
// dout always presents the oldest entry; full/empty come straight from the occupancy count.
module sync_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // A simultaneous push and pop leaves the occupancy unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/frame_buffer.sv
// Double-buffered pixel store: the tracer fills the back bank while VGA scans the front bank.
// Define FRAME_BUFFER_CLEAR_ON_SWAP_EN to paint the new back bank with BG_COLOR after every swap.
module frame_buffer
    import frame_buffer_pkg::*;
#(
    parameter int            AW         = 7,
    parameter int            DW         = 12,
    parameter int            FIFO_DEPTH = 4,
    parameter logic [DW-1:0] BG_COLOR   = DEFAULT_BG
) (
    input  logic          vga_clk,
    input  logic          clr,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_x,
    input  logic [AW-1:0] wr_y,
    input  logic [DW-1:0] wr_data,
    input  logic          frame_done,
    input  logic          vs,
    input  logic [AW-1:0] rd_col,
    input  logic [AW-1:0] rd_row,
    output logic [DW-1:0] rd_data,
    output logic          front_sel,
    output logic          swap_pending,
    output logic [7:0]    frame_count
);

    localparam int MW = 2*AW;
    localparam int FW = MW + DW;

    // Both banks share one array; the top address bit selects the bank.
    logic [DW-1:0] mem [0:(2**(MW+1))-1];

    state_t        state;
    logic          vs_d;
    logic [MW-1:0] clear_addr;

    logic          fifo_full;
    logic          fifo_empty;
    logic [FW-1:0] fifo_dout;
    logic          push;
    logic          pop;
    logic          vs_fall;

    logic          ram_we;
    logic [MW:0]   ram_waddr;
    logic [DW-1:0] ram_wdata;

    assign wr_ready = !clr && (state == IDLE) && !fifo_full;
    assign push     = wr_valid && wr_ready;
    assign pop      = !fifo_empty;
    assign vs_fall  = vs_d && !vs;

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (vga_clk),
        .rst   (clr),
        .push  (push),
        .din   ({wr_y, wr_x, wr_data}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = {~front_sel, fifo_dout[FW-1:DW]};
        ram_wdata = fifo_dout[DW-1:0];
        if (pop) begin
            ram_we = 1'b1;
        end else if (state == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = {~front_sel, clear_addr};
            ram_wdata = BG_COLOR;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
    end

    // Writes always target the other bank, so the scan-out read never collides with them.
    always_ff @(posedge vga_clk or posedge clr) begin
        if (clr) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[{front_sel, rd_row, rd_col}];
        end
    end

    // Drain empty means the final pop was already written on its own edge.
    always_ff @(posedge vga_clk or posedge clr) begin
        if (clr) begin
            state        <= IDLE;
            vs_d         <= 1'b1;
            front_sel    <= 1'b0;
            swap_pending <= 1'b0;
            frame_count  <= 8'd0;
            clear_addr   <= '0;
        end else begin
            vs_d <= vs;
            case (state)
                IDLE: begin
                    if (frame_done) begin
                        state        <= DRAIN;
                        swap_pending <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (fifo_empty) state <= WAIT_VS;
                end
                WAIT_VS: begin
                    if (vs_fall) begin
                        front_sel    <= ~front_sel;
                        frame_count  <= frame_count + 8'd1;
                        swap_pending <= 1'b0;
                        clear_addr   <= '0;
`ifdef FRAME_BUFFER_CLEAR_ON_SWAP_EN
                        state        <= CLEAR;
`else
                        state        <= IDLE;
`endif
                    end
                end
                CLEAR: begin
                    clear_addr <= clear_addr + 1'b1;
                    if (clear_addr == {MW{1'b1}}) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
